// File: rtl/stride_pkg.sv
// Shared definitions for the stride read path (address generator and completion detector).
// Contents:
//   DEF_ADDR_WIDTH / DEF_BUF_DEPTH  default pointer width and circular buffer depth
//   ST_IDLE / ST_RUN / ST_DONE      state encodings
//   stride_state_e                  typed FSM state built on those encodings
package stride_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_BUF_DEPTH  = 256;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } stride_state_e;

endpackage

// File: rtl/circ_ptr_incr.sv
// Circular-buffer pointer increment: next = (ptr == BUF_DEPTH-1) ? 0 : ptr + 1.
// Shared by the read-address generator and the buffer write side.
// Ports:
//   ptr_i   current pointer
//   next_o  successor pointer, wrapping at BUF_DEPTH-1
module circ_ptr_incr
  import stride_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic [ADDR_WIDTH-1:0] ptr_i,
  output logic [ADDR_WIDTH-1:0] next_o
);

  localparam logic [ADDR_WIDTH-1:0] LastPtr = ADDR_WIDTH'(BUF_DEPTH - 1);

  always_comb begin
    if (ptr_i == LastPtr) begin
      next_o = '0;
    end else begin
      next_o = ptr_i + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/stride_read_addr_gen.sv
// Generates the circular-buffer read address sequence for one stride (start_ptr..end_ptr
// inclusive, wrapping at BUF_DEPTH-1) and hands read_addr/end_ptr_o/ep_valid to the
// downstream completion detector.
// Optional feature: define STRIDE_GEN_BEAT_CNT_EN to add the beat_cnt output.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           begin a stride (sampled in IDLE only)
//   flush           synchronous abort, wins over start and beats
//   start_ptr       first address of the stride
//   end_ptr         last address of the stride, inclusive
//   data_avail      entry at read_addr readable this cycle
//   rd_en           read strobe; a beat is rd_en & data_avail
//   read_addr       current read address (registered)
//   end_ptr_o       latched end pointer (registered)
//   ep_valid        read_addr/end_ptr_o valid for the detector
//   busy            FSM not idle
//   done            one-cycle completion pulse
//   beat_cnt        beats issued in the current stride (optional)
module stride_read_addr_gen
  import stride_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] start_ptr,
  input  logic [ADDR_WIDTH-1:0] end_ptr,
  input  logic                  data_avail,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [ADDR_WIDTH-1:0] end_ptr_o,
  output logic                  ep_valid,
  output logic                  busy,
  output logic                  done
`ifdef STRIDE_GEN_BEAT_CNT_EN
  ,
  output logic [ADDR_WIDTH:0]   beat_cnt
`endif
);

  stride_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic                  ep_valid_q, ep_valid_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  beat;

  circ_ptr_incr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_addr_incr (
    .ptr_i  (addr_q),
    .next_o (addr_next)
  );

  assign beat = (state_q == StRun) && data_avail;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    end_d      = end_q;
    ep_valid_d = ep_valid_q;
    done_d     = 1'b0;
    if (flush) begin
      // Abort without a done pulse; pointers are left as they were.
      state_d    = StIdle;
      ep_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_d     = start_ptr;
            end_d      = end_ptr;
            ep_valid_d = 1'b1;
            state_d    = StRun;
          end
        end
        StRun: begin
          if (beat) begin
            if (addr_q == end_q) begin
              // Final address issued; hold it so the detector sees the match in DONE.
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              addr_d = addr_next;
            end
          end
        end
        StDone: begin
          ep_valid_d = 1'b0;
          state_d    = StIdle;
        end
        default: begin
          state_d    = StIdle;
          ep_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      end_q      <= '0;
      ep_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      ep_valid_q <= ep_valid_d;
      done_q     <= done_d;
    end
  end

  assign rd_en     = beat;
  assign read_addr = addr_q;
  assign end_ptr_o = end_q;
  assign ep_valid  = ep_valid_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

`ifdef STRIDE_GEN_BEAT_CNT_EN
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush || ((state_q == StIdle) && start)) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt = cnt_q;
`endif

endmodule
